// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Synchronises, debounces and edge-detects a raw push-button pin;
//            provides clean level, press/release strobes, toggle and counter.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int LOG2STABLE = 16,
    parameter bit INVERT     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic       toggle,
    output logic [7:0] press_count
);

    localparam logic [LOG2STABLE-1:0] c_cnt_max = '1;

    logic                  r_s1;
    logic                  r_s2;
    logic [LOG2STABLE-1:0] r_cnt;
    logic                  r_level;
    logic                  r_rise;
    logic                  r_fall;
    logic                  r_toggle;
    logic [7:0]            r_press_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_cnt         <= '0;
            r_level       <= 1'b0;
            r_rise        <= 1'b0;
            r_fall        <= 1'b0;
            r_toggle      <= 1'b0;
            r_press_count <= 8'h00;
        end else begin
            r_s1   <= btn_in ^ INVERT;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the window
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt   <= '0;
                r_level <= r_s2;
                r_rise  <= r_s2;
                r_fall  <= ~r_s2;
                if (r_s2) begin
                    r_toggle      <= ~r_toggle;
                    r_press_count <= r_press_count + 8'd1;
                end
            end
        end
    end

    assign level       = r_level;
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign toggle      = r_toggle;
    assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Directed bench for button_conditioner with a per-cycle
//            behavioural model plus literal expectations at key points.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int LOG2 = 3;
    localparam int N    = 1 << LOG2;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       btn    = 1'b0;
    logic       btn_n  = 1'b1;
    logic       level, rise, fall, toggle;
    logic [7:0] press_count;
    logic       level_i, rise_i, fall_i, toggle_i;
    logic [7:0] count_i;

    always #5 clk = ~clk;

    button_conditioner #(.LOG2STABLE(LOG2), .INVERT(1'b0)) dut (
        .clk(clk), .rst(rst), .btn_in(btn), .level(level), .rise(rise),
        .fall(fall), .toggle(toggle), .press_count(press_count)
    );

    button_conditioner #(.LOG2STABLE(LOG2), .INVERT(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .btn_in(btn_n), .level(level_i), .rise(rise_i),
        .fall(fall_i), .toggle(toggle_i), .press_count(count_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: a change is accepted once the pin (seen two edges late) has
    // differed from the accepted level for N consecutive edges.
    int         hist[$];
    logic       m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_toggle = 1'b0;
    logic [7:0] m_count = 8'h00;

    always @(posedge clk) begin
        bit   all_diff;
        int   idx;
        int   v;
        logic nl;
        if (rst) begin
            hist.delete();
            m_level  <= 1'b0;
            m_rise   <= 1'b0;
            m_fall   <= 1'b0;
            m_toggle <= 1'b0;
            m_count  <= 8'h00;
        end else begin
            hist.push_back(int'(btn));
            if (hist.size() > N + 2) void'(hist.pop_front());
            all_diff = 1'b1;
            for (int j = 0; j < N; j++) begin
                idx = hist.size() - 3 - j;
                v   = (idx >= 0) ? hist[idx] : 0;
                if (v == int'(m_level)) all_diff = 1'b0;
            end
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (all_diff) begin
                nl = ~m_level;
                m_level <= nl;
                if (nl) begin
                    m_rise   <= 1'b1;
                    m_toggle <= ~m_toggle;
                    m_count  <= m_count + 8'd1;
                end else begin
                    m_fall <= 1'b1;
                end
            end
        end
    end

    bit cmp_on = 1'b0;
    int n_rise = 0;
    int n_fall = 0;

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_level",  int'(level),       int'(m_level));
            chk("model_rise",   int'(rise),        int'(m_rise));
            chk("model_fall",   int'(fall),        int'(m_fall));
            chk("model_toggle", int'(toggle),      int'(m_toggle));
            chk("model_count",  int'(press_count), int'(m_count));
            chk("rise_fall_excl", int'(rise & fall), 0);
        end
        if (rise) n_rise <= n_rise + 1;
        if (fall) n_fall <= n_fall + 1;
    end

    initial begin
        int r0;
        int f0;
        // 1: reset and idle
        repeat (4) @(negedge clk);
        cmp_on = 1'b1;
        chk("rst_level", int'(level), 0);
        chk("rst_rise", int'(rise), 0);
        chk("rst_toggle", int'(toggle), 0);
        chk("rst_count", int'(press_count), 0);
        rst = 1'b0;
        repeat (50) tick();
        chk("idle_level", int'(level), 0);
        chk("idle_count", int'(press_count), 0);
        chk("inv_idle_level", int'(level_i), 0);

        // 2: clean press then release
        btn = 1'b1;
        repeat (9) tick();
        chk("press_level_k8", int'(level), 0);
        tick();
        chk("press_level_k9", int'(level), 1);
        chk("press_rise_k9", int'(rise), 1);
        tick();
        chk("press_rise_after", int'(rise), 0);
        chk("press_toggle", int'(toggle), 1);
        chk("press_count", int'(press_count), 1);
        btn = 1'b0;
        repeat (9) tick();
        chk("rel_level_k8", int'(level), 1);
        tick();
        chk("rel_level_k9", int'(level), 0);
        chk("rel_fall_k9", int'(fall), 1);
        tick();
        chk("rel_fall_after", int'(fall), 0);
        chk("rel_toggle", int'(toggle), 1);
        chk("rel_count", int'(press_count), 1);

        // 3: glitch, then bounce settling high
        r0 = n_rise;
        btn = 1'b1;
        repeat (5) tick();
        btn = 1'b0;
        repeat (12) tick();
        chk("glitch_level", int'(level), 0);
        chk("glitch_count", int'(press_count), 1);
        chk("glitch_rises", n_rise - r0, 0);
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0);
            repeat (3) tick();
        end
        btn = 1'b1;
        repeat (9) tick();
        chk("bounce_level_k8", int'(level), 0);
        tick();
        chk("bounce_rise_k9", int'(rise), 1);
        tick();
        chk("bounce_rises", n_rise - r0, 1);
        btn = 1'b0;
        repeat (12) tick();

        // 4: 256 presses wrap the counter
        rst = 1'b1;
        repeat (2) tick();
        chk("rst2_count", int'(press_count), 0);
        rst = 1'b0;
        r0 = n_rise;
        f0 = n_fall;
        for (int i = 0; i < 256; i++) begin
            btn = 1'b1;
            repeat (12) tick();
            btn = 1'b0;
            repeat (12) tick();
        end
        chk("wrap_count", int'(press_count), 0);
        chk("wrap_toggle", int'(toggle), 0);
        chk("wrap_rises", n_rise - r0, 256);
        chk("wrap_falls", n_fall - f0, 256);

        // 5: reset on the 5th counting edge with the button held
        btn = 1'b1;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("midrst_level", int'(level), 0);
        chk("midrst_count", int'(press_count), 0);
        chk("midrst_toggle", int'(toggle), 0);
        tick();
        rst = 1'b0;
        repeat (9) tick();
        chk("requal_level_k8", int'(level), 0);
        tick();
        chk("requal_rise_k9", int'(rise), 1);
        chk("requal_count", int'(press_count), 1);
        btn = 1'b0;
        repeat (12) tick();

        // 6: active-low instance
        chk("inv_held_idle", int'(level_i), 0);
        btn_n = 1'b0;
        repeat (9) tick();
        chk("inv_level_k8", int'(level_i), 0);
        tick();
        chk("inv_level_k9", int'(level_i), 1);
        chk("inv_rise_k9", int'(rise_i), 1);
        repeat (2) tick();
        chk("inv_count", int'(count_i), 1);
        chk("inv_toggle", int'(toggle_i), 1);
        chk("inv_fall", int'(fall_i), 0);

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
